// File: rtl/count_enable_debouncer.sv
// Synchronises and debounces a raw switch, driving the ripple counter's toggle-enable
// as a level or one pulse per press. Optional auto-repeat in pulse mode: AUTO_REPEAT_EN.
module count_enable_debouncer #(
  parameter int DB_CYCLES     = 4,
  parameter int DB_W          = 3,
  parameter int REPEAT_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_in,
  input  logic mode,
  output logic x,
  output logic level,
  output logic busy
);

  localparam logic [1:0] IDLE_LOW   = 2'd0;
  localparam logic [1:0] CHECK_HIGH = 2'd1;
  localparam logic [1:0] IDLE_HIGH  = 2'd2;
  localparam logic [1:0] CHECK_LOW  = 2'd3;

  localparam logic [DB_W-1:0] CNT_ZERO = {DB_W{1'b0}};
  localparam logic [DB_W-1:0] CNT_ONE  = DB_W'(1'b1);
  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync1_r;
  logic            sync2_r;
  logic [1:0]      state_r;
  logic [DB_W-1:0] cnt_r;
  logic            level_r;
  logic            x_r;
  logic            busy_r;

  logic [1:0]      state_next_s;
  logic [DB_W-1:0] cnt_next_s;
  logic            level_next_s;
  logic            rise_s;
  logic            rep_pulse_s;
  logic            x_next_s;

  assign x     = x_r;
  assign level = level_r;
  assign busy  = busy_r;

  // Two-flop synchroniser for the asynchronous switch input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= sw_in;
      sync2_r <= sync1_r;
    end
  end

  // Debounce FSM next-state: a change is accepted after DB_CYCLES matching samples.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    level_next_s = level_r;
    rise_s       = 1'b0;
    case (state_r)
      IDLE_LOW: begin
        if (sync2_r) begin
          if (DB_CYCLES == 1) begin
            state_next_s = IDLE_HIGH;
            cnt_next_s   = CNT_ZERO;
            level_next_s = 1'b1;
            rise_s       = 1'b1;
          end else begin
            state_next_s = CHECK_HIGH;
            cnt_next_s   = CNT_ONE;
          end
        end else begin
          cnt_next_s = CNT_ZERO;
        end
      end
      CHECK_HIGH: begin
        if (!sync2_r) begin
          state_next_s = IDLE_LOW;
          cnt_next_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_next_s = IDLE_HIGH;
          cnt_next_s   = CNT_ZERO;
          level_next_s = 1'b1;
          rise_s       = 1'b1;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!sync2_r) begin
          if (DB_CYCLES == 1) begin
            state_next_s = IDLE_LOW;
            cnt_next_s   = CNT_ZERO;
            level_next_s = 1'b0;
          end else begin
            state_next_s = CHECK_LOW;
            cnt_next_s   = CNT_ONE;
          end
        end else begin
          cnt_next_s = CNT_ZERO;
        end
      end
      CHECK_LOW: begin
        if (sync2_r) begin
          state_next_s = IDLE_HIGH;
          cnt_next_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_next_s = IDLE_LOW;
          cnt_next_s   = CNT_ZERO;
          level_next_s = 1'b0;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_next_s = IDLE_LOW;
        cnt_next_s   = CNT_ZERO;
        level_next_s = 1'b0;
      end
    endcase
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [7:0] REP_LAST = 8'(REPEAT_CYCLES - 1);

  logic [7:0] rep_r;
  logic [7:0] rep_next_s;

  // Repeat timer runs while the accepted level is high; it never fires on the falling accept.
  always_comb begin
    rep_next_s  = rep_r;
    rep_pulse_s = 1'b0;
    if (rise_s) begin
      rep_next_s = 8'd0;
    end else if ((state_r == IDLE_HIGH) || (state_r == CHECK_LOW)) begin
      if (rep_r == REP_LAST) begin
        rep_next_s  = 8'd0;
        rep_pulse_s = level_next_s;
      end else begin
        rep_next_s = rep_r + 8'd1;
      end
    end else begin
      rep_next_s = rep_r;
    end
  end

  // Repeat timer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_r <= 8'd0;
    end else begin
      rep_r <= rep_next_s;
    end
  end
`else
  assign rep_pulse_s = 1'b0;
`endif

  // Output select: level follows the debounced state, pulse mode emits on rise (and repeat).
  always_comb begin
    if (mode) begin
      x_next_s = rise_s | rep_pulse_s;
    end else begin
      x_next_s = level_next_s;
    end
  end

  // FSM and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE_LOW;
      cnt_r   <= CNT_ZERO;
      level_r <= 1'b0;
      x_r     <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      level_r <= level_next_s;
      x_r     <= x_next_s;
      busy_r  <= (state_next_s == CHECK_HIGH) || (state_next_s == CHECK_LOW);
    end
  end

endmodule
